// File: rtl/cnn_layer_accel_weight_sequence_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : cnn_layer_accel_weight_sequence_gen_if
// Brief    : Control/table bundle between the QUAD FSM, the weight sequence
//            generator and the weight sequence table.
//            Optional: CNN_LAYER_ACCEL_WHT_SEQ_GEN_STATUS_EN adds pass_cnt_out.
// Revision : 1.0
// ============================================================================
interface cnn_layer_accel_weight_sequence_gen_if #(
  parameter int ADDR_W = 3,
  parameter int PASS_W = 16
);
  logic              start;
  logic [PASS_W-1:0] num_passes;
  logic              sel_init;
  logic              advance;
  logic              busy;
  logic              done;
  logic [1:0]        gray_code;
  logic              sequence_selector;
  logic [ADDR_W-1:0] seq_data_addr;
  logic              seq_valid;
  logic              wht_addr_valid;
`ifdef CNN_LAYER_ACCEL_WHT_SEQ_GEN_STATUS_EN
  logic [PASS_W-1:0] pass_cnt_out;

  modport master (
    input  start, num_passes, sel_init, advance,
    output busy, done, gray_code, sequence_selector, seq_data_addr,
           seq_valid, wht_addr_valid, pass_cnt_out
  );
  modport slave (
    output start, num_passes, sel_init, advance,
    input  busy, done, gray_code, sequence_selector, seq_data_addr,
           seq_valid, wht_addr_valid, pass_cnt_out
  );
`else
  modport master (
    input  start, num_passes, sel_init, advance,
    output busy, done, gray_code, sequence_selector, seq_data_addr,
           seq_valid, wht_addr_valid
  );
  modport slave (
    output start, num_passes, sel_init, advance,
    input  busy, done, gray_code, sequence_selector, seq_data_addr,
           seq_valid, wht_addr_valid
  );
`endif
endinterface
`default_nettype wire

// File: rtl/cnn_layer_accel_weight_sequence_gen.sv
`default_nettype none
// ============================================================================
// Module   : cnn_layer_accel_weight_sequence_gen
// Brief    : Walks gray_code/sequence_selector/seq_data_addr over the weight
//            sequence table for a programmed number of passes.
//            Optional: CNN_LAYER_ACCEL_WHT_SEQ_GEN_STATUS_EN exports pass count.
// Revision : 1.0
// ============================================================================
module cnn_layer_accel_weight_sequence_gen #(
  parameter int SEQ_LEN = 5,
  parameter int ADDR_W  = 3,
  parameter int PASS_W  = 16,
  parameter int TBL_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  cnn_layer_accel_weight_sequence_gen_if.master bus
);

  localparam logic [1:0]        c_idle      = 2'd0;
  localparam logic [1:0]        c_run       = 2'd1;
  localparam logic [1:0]        c_done      = 2'd2;
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(SEQ_LEN - 1);

  logic [1:0]         state_q, state_d;
  logic [PASS_W-1:0]  num_passes_q, num_passes_d;
  logic [PASS_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [1:0]         gray_q, gray_d;
  logic               sel_q, sel_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               seq_valid_q, seq_valid_d;
  logic [TBL_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic               w_step;
  logic               w_end_of_pass;

  always_comb begin
    w_step        = seq_valid_q & bus.advance;
    w_end_of_pass = w_step && (addr_q == c_last_addr);
    state_d       = state_q;
    num_passes_d  = num_passes_q;
    pass_cnt_d    = pass_cnt_q;
    gray_d        = gray_q;
    sel_d         = sel_q;
    addr_d        = addr_q;
    // Shift in the accepted-request strobe; the cast keeps the low TBL_LAT bits.
    vld_pipe_d    = TBL_LAT'({vld_pipe_q, w_step});

    case (state_q)
      c_idle: begin
        if (bus.start) begin
          pass_cnt_d = '0;
          if (bus.num_passes != '0) begin
            num_passes_d = bus.num_passes;
            gray_d       = 2'b00;
            addr_d       = '0;
            sel_d        = bus.sel_init;
            state_d      = c_run;
          end else begin
            state_d = c_done;
          end
        end
      end
      c_run: begin
        if (w_end_of_pass) begin
          pass_cnt_d = pass_cnt_q + PASS_W'(1);
          // Final pass leaves the table index parked on its last value.
          if (pass_cnt_q == num_passes_q - PASS_W'(1)) begin
            state_d = c_done;
          end else begin
            addr_d = '0;
            gray_d = {gray_q[0], ~gray_q[1]};
            if (gray_q == 2'b10) begin
              sel_d = ~sel_q;
            end
          end
        end else if (w_step) begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      c_done:  state_d = c_idle;
      default: state_d = c_idle;
    endcase

    busy_d      = (state_d == c_run);
    seq_valid_d = (state_d == c_run);
    done_d      = (state_d == c_done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= c_idle;
      num_passes_q <= '0;
      pass_cnt_q   <= '0;
      gray_q       <= 2'b00;
      sel_q        <= 1'b0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      seq_valid_q  <= 1'b0;
      vld_pipe_q   <= '0;
    end else begin
      state_q      <= state_d;
      num_passes_q <= num_passes_d;
      pass_cnt_q   <= pass_cnt_d;
      gray_q       <= gray_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      seq_valid_q  <= seq_valid_d;
      vld_pipe_q   <= vld_pipe_d;
    end
  end

  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.gray_code         = gray_q;
  assign bus.sequence_selector = sel_q;
  assign bus.seq_data_addr     = addr_q;
  assign bus.seq_valid         = seq_valid_q;
  assign bus.wht_addr_valid    = vld_pipe_q[TBL_LAT-1];
`ifdef CNN_LAYER_ACCEL_WHT_SEQ_GEN_STATUS_EN
  assign bus.pass_cnt_out      = pass_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_accel_weight_sequence_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_layer_accel_weight_sequence_gen
// Brief    : Directed plus random stimulus against a step-count reference model.
//            Honours CNN_LAYER_ACCEL_WHT_SEQ_GEN_STATUS_EN when defined.
// Revision : 1.0
// ============================================================================
module tb_cnn_layer_accel_weight_sequence_gen;
  localparam int SEQ_LEN = 5;
  localparam int ADDR_W  = 3;
  localparam int PASS_W  = 16;
  localparam int TBL_LAT = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnn_layer_accel_weight_sequence_gen_if #(.ADDR_W(ADDR_W), .PASS_W(PASS_W)) bus ();

  cnn_layer_accel_weight_sequence_gen #(
    .SEQ_LEN(SEQ_LEN), .ADDR_W(ADDR_W), .PASS_W(PASS_W), .TBL_LAT(TBL_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the run is described by how many steps were accepted.
  bit       m_busy, m_done, m_valid, m_sel, m_sel0;
  bit [1:0] m_gray;
  int       m_addr, m_steps, m_total;
  bit       m_pipe [TBL_LAT];
  bit [1:0] gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_out(input int k);
    int pass;
    pass   = k / SEQ_LEN;
    m_addr = k % SEQ_LEN;
    m_gray = gray_tab[pass % 4];
    m_sel  = m_sel0 ^ bit'((pass / 4) % 2);
  endfunction

  task automatic cycle(input bit st, input int np, input bit si, input bit adv, input bit r);
    rst            = r;
    bus.start      = st;
    bus.num_passes = PASS_W'(np);
    bus.sel_init   = si;
    bus.advance    = adv;
    @(posedge clk);
    if (r) begin
      m_busy = 0; m_done = 0; m_valid = 0; m_sel = 0; m_gray = 2'b00;
      m_addr = 0; m_steps = 0;
      for (int i = 0; i < TBL_LAT; i++) m_pipe[i] = 0;
    end else begin
      for (int i = TBL_LAT - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = m_valid & adv;
      if (m_busy) begin
        if (adv) begin
          m_steps++;
          if (m_steps == m_total) begin
            m_busy = 0; m_valid = 0; m_done = 1;
          end else begin
            model_out(m_steps);
          end
        end
      end else if (m_done) begin
        m_done = 0;
      end else if (st) begin
        m_steps = 0;
        if (np == 0) begin
          m_done = 1;
        end else begin
          m_busy = 1; m_valid = 1; m_total = np * SEQ_LEN; m_sel0 = si;
          model_out(0);
        end
      end
    end
    #1;
    check_eq("busy",  32'(bus.busy),              32'(m_busy));
    check_eq("done",  32'(bus.done),              32'(m_done));
    check_eq("gray",  32'(bus.gray_code),         32'(m_gray));
    check_eq("sel",   32'(bus.sequence_selector), 32'(m_sel));
    check_eq("addr",  32'(bus.seq_data_addr),     32'(m_addr));
    check_eq("valid", 32'(bus.seq_valid),         32'(m_valid));
    check_eq("wav",   32'(bus.wht_addr_valid),    32'(m_pipe[TBL_LAT-1]));
`ifdef CNN_LAYER_ACCEL_WHT_SEQ_GEN_STATUS_EN
    check_eq("pcnt",  32'(bus.pass_cnt_out),      32'(m_steps / SEQ_LEN));
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.num_passes = '0; bus.sel_init = 1'b0; bus.advance = 1'b0;

    repeat (2)  cycle(0, 0, 0, 0, 1);
    repeat (10) cycle(0, 0, 0, 0, 0);

    // Single pass, selector preset high.
    cycle(1, 1, 1, 1, 0);
    repeat (8) cycle(0, 1, 0, 1, 0);

    // Eight passes walk the full gray cycle twice.
    cycle(1, 8, 0, 1, 0);
    repeat (45) cycle(0, 0, 1, 1, 0);

    // Alternating back-pressure.
    cycle(1, 2, 0, 1, 0);
    for (int i = 0; i < 25; i++) cycle(0, 2, 0, bit'(i % 2), 0);

    // Zero passes, then a restart attempt while busy.
    cycle(1, 0, 1, 1, 0);
    repeat (3) cycle(0, 0, 0, 1, 0);
    cycle(1, 3, 0, 1, 0);
    repeat (4) cycle(0, 3, 0, 1, 0);
    cycle(1, 7, 1, 1, 0);
    repeat (14) cycle(0, 3, 0, 1, 0);

    // Reset mid-run at pass 1, addr 2, then a clean relaunch.
    cycle(1, 3, 1, 1, 0);
    repeat (7) cycle(0, 3, 1, 1, 0);
    cycle(0, 3, 1, 1, 1);
    repeat (2) cycle(0, 3, 1, 1, 0);
    cycle(1, 2, 0, 1, 0);
    repeat (12) cycle(0, 2, 0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 8) == 0,
            (($urandom % 6) == 0) ? 0 : int'($urandom_range(1, 4)),
            bit'($urandom % 2),
            ($urandom % 4) != 0,
            ($urandom % 200) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
